mem_loader: RTL and testbench
=============================

// Module: mem_loader
// PURPOSE
// Hardware successor to the file-driven memory preload sequence. Accepts a byte stream, packs it into
// DATA_LEN-bit words and writes them to mem at consecutive addresses from 0. It then replays a read
// sweep over every written word to feed fetch, and waits a bounded time for computation_end.
// Sits between the byte source (file model / host link) and the mem/fetch pair.
// Generalised over word width, depth, byte order and timeout; adds padding, overflow and timeout status.
// PARAMETERS
// DATA_LEN    40    memory word width; must be a multiple of 8; CHAR_PART = DATA_LEN/8
// ADDR_LEN    11    memory address width; depth ADDRS = 2**ADDR_LEN
// BIG_ENDIAN  1     1: first byte lands in MSB lane; 0: first byte lands in LSB lane
// TIMEOUT     50    maximum WAIT cycles for computation_end
// PORTS
// clk              in   1           single clock, all logic on posedge
// rst              in   1           synchronous, active-low reset (0 = reset)
// in_valid         in   1           byte available on in_data
// in_ready         out  1           loader accepts a byte this cycle
// in_data          in   8           stream byte
// in_last          in   1           marks final byte of stream (qualified by valid&ready)
// mem_wr           out  1           memory write strobe
// mem_rd           out  1           memory read strobe
// mem_addr         out  ADDR_LEN    memory address
// mem_wdata        out  DATA_LEN    packed write word
// computation_end  in   1           fetch reports completion
// word_count       out  ADDR_LEN+1  number of words written (0..ADDRS)
// done             out  1           sticky: computation_end seen in WAIT
// timeout          out  1           sticky: TIMEOUT expired in WAIT
// overflow         out  1           sticky: at least one word dropped because memory was full
// BEHAVIOUR
// Reset (rst=0 at posedge): state LOAD; all outputs 0 except in_ready=0 in the reset cycle;
//   accumulator, byte counter and word_count cleared. Reset mid-operation aborts immediately, with no
//   partial write.
// All outputs are registered. A byte is accepted when in_valid & in_ready.
// LOAD: in_ready=1. Each accepted byte is placed in lane byte_cnt (BIG_ENDIAN: lane CHAR_PART-1-byte_cnt).
//   On the CHAR_PART-th byte, mem_wr=1 on the next cycle with mem_addr=word_count and the packed
//   mem_wdata. word_count increments in that same cycle and byte_cnt wraps to 0.
//   Back-to-back bytes sustain one word per CHAR_PART cycles; in_ready stays 1 during the write cycle.
// in_last on a word-completing byte: that word is written, then state becomes READ.
// in_last on a partial byte: state becomes FLUSH, in_ready=0, and one write follows with unfilled lanes
//   zero. byte_cnt==0 is impossible at that point, so a flush never writes an empty word.
// in_last with no bytes pending is the same case as a word-completing byte.
// Full: if word_count==ADDRS when a word completes, there is no mem_wr, overflow=1, and word_count holds.
//   Bytes keep being consumed until in_last.
// READ: mem_rd=1 and mem_addr=0,1,...,word_count-1, one per cycle, for exactly word_count cycles.
//   Then mem_rd=0 and state becomes WAIT. If word_count==0, READ goes straight to WAIT with no rd pulse.
// WAIT: a cycle counter runs from 0. computation_end=1 goes to DONE with done=1.
//   When the counter reaches TIMEOUT-1 without computation_end: DONE with timeout=1.
//   If both occur in the same cycle, done wins (done=1, timeout=0).
//   computation_end is ignored in all states except WAIT.
// DONE: terminal; in_ready=0, mem_rd=mem_wr=0; status flags hold until reset.
// mem_addr holds its last value whenever no strobe is active.
// TESTING
// 1) 10 bytes 01..0A with in_last on 0A, BIG_ENDIAN=1 -> writes 0x0102030405@0 and 0x060708090A@1;
//    word_count=2.
// 2) 7 bytes 01..07 with last on 07 -> 0x0102030405@0, then FLUSH writes 0x0607000000@1;
//    with BIG_ENDIAN=0 the words are 0x0504030201 and 0x0000000706.
// 3) After scenario 1 -> mem_rd high exactly 2 cycles with addr 0,1; computation_end pulsed at
//    WAIT cycle 3 -> done=1, timeout=0.
// 4) No computation_end -> timeout=1 exactly TIMEOUT cycles after WAIT entry; done=0; outputs frozen.
// 5) ADDR_LEN=2 with 5 words streamed -> 4 writes at addr 0..3, overflow=1, word_count=4,
//    read sweep 4 words.
// 6) rst=0 asserted mid-word (2 bytes accepted) -> next cycle all outputs 0, no mem_wr; a new stream
//    restarts at addr 0.

Source files
------------

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - byte stream to word packer with memory preload, read sweep and completion wait
module mem_loader #(
    parameter int DATA_LEN   = 40,
    parameter int ADDR_LEN   = 11,
    parameter int BIG_ENDIAN = 1,
    parameter int TIMEOUT    = 50
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_data,
    input  logic                in_last,
    output logic                mem_wr,
    output logic                mem_rd,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_wdata,
    input  logic                computation_end,
    output logic [ADDR_LEN:0]   word_count,
    output logic                done,
    output logic                timeout,
    output logic                overflow
);
    localparam int CHAR_PART = DATA_LEN / 8;
    localparam int BCW       = (CHAR_PART > 1) ? $clog2(CHAR_PART) : 1;
    localparam int TW        = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_LEN:0] FULL = {1'b1, {ADDR_LEN{1'b0}}};

    typedef enum logic [2:0] {LOAD, FLUSH, READ, WAIT, DONE} state_t;

    state_t              state;
    logic [DATA_LEN-1:0] acc;
    logic [DATA_LEN-1:0] acc_next;
    logic [BCW-1:0]      byte_cnt;
    logic [BCW-1:0]      lane;
    logic [ADDR_LEN:0]   rd_idx;
    logic [TW-1:0]       wait_cnt;
    logic                accept;
    logic                word_end;
    logic                commit;
    logic [DATA_LEN-1:0] commit_data;

    assign accept   = in_valid && in_ready && (state == LOAD);
    assign word_end = (byte_cnt == BCW'(CHAR_PART - 1));
    assign lane     = (BIG_ENDIAN != 0) ? BCW'(CHAR_PART - 1) - byte_cnt : byte_cnt;

    always_comb begin
        acc_next = acc;
        for (int i = 0; i < CHAR_PART; i++) begin
            if (lane == BCW'(i)) begin
                acc_next[8*i +: 8] = in_data;
            end
        end
    end

    // A word is committed either by its final byte in LOAD or by the single FLUSH cycle.
    assign commit      = (accept && word_end) || (state == FLUSH);
    assign commit_data = (state == FLUSH) ? acc : acc_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= LOAD;
            in_ready   <= 1'b0;
            mem_wr     <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            overflow   <= 1'b0;
            acc        <= '0;
            byte_cnt   <= '0;
            rd_idx     <= '0;
            wait_cnt   <= '0;
        end else begin
            mem_wr <= 1'b0;
            mem_rd <= 1'b0;

            if (commit) begin
                if (word_count == FULL) begin
                    overflow <= 1'b1;
                end else begin
                    mem_wr     <= 1'b1;
                    mem_addr   <= word_count[ADDR_LEN-1:0];
                    mem_wdata  <= commit_data;
                    word_count <= word_count + 1'b1;
                end
            end

            case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (word_end) begin
                            acc      <= '0;
                            byte_cnt <= '0;
                        end else begin
                            acc      <= acc_next;
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                        if (in_last) begin
                            in_ready <= 1'b0;
                            rd_idx   <= '0;
                            state    <= word_end ? READ : FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    acc      <= '0;
                    byte_cnt <= '0;
                    state    <= READ;
                end
                READ: begin
                    if (rd_idx < word_count) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= rd_idx[ADDR_LEN-1:0];
                        rd_idx   <= rd_idx + 1'b1;
                    end else begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // computation_end takes priority over an expiring counter.
                    if (computation_end) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        timeout <= 1'b1;
                        state   <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - randomized self-checking bench for mem_loader (big- and little-endian instances)
module tb_mem_loader;
    localparam int DL   = 40;
    localparam int TO_B = 50;
    localparam int TO_L = 12;

    typedef struct {
        int          inst;
        int          kind;
        int          cyc;
        int          addr;
        logic [39:0] data;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       computation_end = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic          in_ready_b, mem_wr_b, mem_rd_b, done_b, timeout_b, overflow_b;
    logic [1:0]    mem_addr_b;
    logic [DL-1:0] mem_wdata_b;
    logic [2:0]    word_count_b;
    logic          in_ready_l, mem_wr_l, mem_rd_l, done_l, timeout_l, overflow_l;
    logic [2:0]    mem_addr_l;
    logic [DL-1:0] mem_wdata_l;
    logic [3:0]    word_count_l;

    mem_loader #(.DATA_LEN(DL), .ADDR_LEN(2), .BIG_ENDIAN(1), .TIMEOUT(TO_B)) u_be (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .in_last(in_last), .mem_wr(mem_wr_b), .mem_rd(mem_rd_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .computation_end(computation_end), .word_count(word_count_b),
        .done(done_b), .timeout(timeout_b), .overflow(overflow_b));

    mem_loader #(.DATA_LEN(DL), .ADDR_LEN(3), .BIG_ENDIAN(0), .TIMEOUT(TO_L)) u_le (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l), .in_data(in_data),
        .in_last(in_last), .mem_wr(mem_wr_l), .mem_rd(mem_rd_l), .mem_addr(mem_addr_l),
        .mem_wdata(mem_wdata_l), .computation_end(computation_end), .word_count(word_count_l),
        .done(done_l), .timeout(timeout_l), .overflow(overflow_l));

    logic        ir_a[2], wr_a[2], rd_a[2], dn_a[2], tm_a[2], ov_a[2];
    int          addr_a[2], wc_a[2];
    logic [39:0] wd_a[2];
    always_comb begin
        ir_a[0] = in_ready_b;  ir_a[1] = in_ready_l;
        wr_a[0] = mem_wr_b;    wr_a[1] = mem_wr_l;
        rd_a[0] = mem_rd_b;    rd_a[1] = mem_rd_l;
        dn_a[0] = done_b;      dn_a[1] = done_l;
        tm_a[0] = timeout_b;   tm_a[1] = timeout_l;
        ov_a[0] = overflow_b;  ov_a[1] = overflow_l;
        addr_a[0] = int'(mem_addr_b);   addr_a[1] = int'(mem_addr_l);
        wc_a[0]   = int'(word_count_b); wc_a[1]   = int'(word_count_l);
        wd_a[0] = mem_wdata_b; wd_a[1] = mem_wdata_l;
    end

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t        obs[$];
    ev_t        exp_q[$];
    logic [7:0] bq[$];
    int         accq[$];
    logic       dn_p[2] = '{1'b0, 1'b0};
    logic       tm_p[2] = '{1'b0, 1'b0};
    int         exp_wc[2], exp_ov[2], exp_dn[2];

    // Event log: 0 write, 1 read, 2 done rising, 3 timeout rising; stamped with the setting edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (wr_a[k]) obs.push_back('{k, 0, cyc, addr_a[k], wd_a[k]});
            if (rd_a[k]) obs.push_back('{k, 1, cyc, addr_a[k], 40'h0});
            if (dn_a[k] && !dn_p[k]) obs.push_back('{k, 2, cyc, 0, 40'h0});
            if (tm_a[k] && !tm_p[k]) obs.push_back('{k, 3, cyc, 0, 40'h0});
            dn_p[k] = dn_a[k];
            tm_p[k] = tm_a[k];
        end
    end

    function automatic int wait_entry(input int k, input int last_cyc);
        int n     = bq.size();
        int nw    = (n + 4) / 5;
        int addrs = (k == 0) ? 4 : 8;
        int f     = (n % 5 != 0) ? 1 : 0;
        int wc    = (nw < addrs) ? nw : addrs;
        return last_cyc + f + wc + 1;
    endfunction

    function automatic void build(input int k, input int last_cyc, input int c);
        int          addrs = (k == 0) ? 4 : 8;
        int          to    = (k == 0) ? TO_B : TO_L;
        logic [63:0] word  = 64'h0;
        int          cnt   = 0;
        int          wc    = 0;
        int          nw    = 0;
        int          f;
        int          w;
        for (int i = 0; i < bq.size(); i++) begin
            if (k == 0) word = (word << 8) | 64'(bq[i]);
            else        word = word | (64'(bq[i]) << (8 * cnt));
            cnt++;
            if (cnt == 5) begin
                nw++;
                if (wc < addrs) begin
                    exp_q.push_back('{k, 0, accq[i], wc, word[39:0]});
                    wc++;
                end
                cnt  = 0;
                word = 64'h0;
            end
        end
        f = (cnt != 0) ? 1 : 0;
        if (f == 1) begin
            nw++;
            if (k == 0) word = word << (8 * (5 - cnt));
            if (wc < addrs) begin
                exp_q.push_back('{k, 0, last_cyc + 1, wc, word[39:0]});
                wc++;
            end
        end
        for (int i = 0; i < wc; i++) exp_q.push_back('{k, 1, last_cyc + 1 + f + i, i, 40'h0});
        w = last_cyc + f + wc + 1;
        if (c >= w + 1 && c <= w + to) begin
            exp_q.push_back('{k, 2, c, 0, 40'h0});
            exp_dn[k] = 1;
        end else begin
            exp_q.push_back('{k, 3, w + to, 0, 40'h0});
            exp_dn[k] = 0;
        end
        exp_wc[k] = wc;
        exp_ov[k] = (nw > addrs) ? 1 : 0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; computation_end = 1'b0;
        @(negedge clk);
        obs.delete();
        rst = 1'b1;
    endtask

    task automatic run_stream(input int ce_off, input string name);
        int idx = 0;
        int guard = 0;
        int n = bq.size();
        int last_cyc, c, w0, w1, endc, hit;
        accq.delete();
        exp_q.delete();
        while (idx < n && guard < 5000) begin
            bit v = ($urandom_range(0, 3) != 0);
            in_valid = v;
            in_data  = v ? bq[idx] : 8'($urandom);
            in_last  = v && (idx == n - 1);
            if (v && ir_a[0]) begin
                accq.push_back(cyc + 1);
                idx++;
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        vectors++;
        if (idx != n) begin
            miscompares++;
            $display("FAIL %s accept: got %0d bytes accepted, expected %0d", name, idx, n);
            return;
        end
        last_cyc = accq[n-1];
        w0 = wait_entry(0, last_cyc);
        w1 = wait_entry(1, last_cyc);
        c  = (ce_off < 0) ? -1 : w0 + 1 + ce_off;
        build(0, last_cyc, c);
        build(1, last_cyc, c);
        endc = (w0 + TO_B > w1 + TO_L) ? w0 + TO_B + 4 : w1 + TO_L + 4;
        if (c + 4 > endc) endc = c + 4;
        while (cyc < endc) begin
            computation_end = (cyc == c - 1);
            @(negedge clk);
        end
        computation_end = 1'b0;
        vectors++;
        if (obs.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL %s event_count: got %0d, expected %0d", name, obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            hit = 0;
            foreach (obs[j])
                if (obs[j].inst == exp_q[i].inst && obs[j].kind == exp_q[i].kind && obs[j].cyc == exp_q[i].cyc
                    && obs[j].addr == exp_q[i].addr && obs[j].data === exp_q[i].data) hit = 1;
            vectors++;
            if (hit == 0) begin
                miscompares++;
                $display("FAIL %s event inst=%0d kind=%0d: got none, expected cyc=%0d addr=%0d data=%h",
                         name, exp_q[i].inst, exp_q[i].kind, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
            end
        end
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (wc_a[k] !== exp_wc[k] || ov_a[k] !== exp_ov[k][0] || dn_a[k] !== exp_dn[k][0]
                || tm_a[k] !== !exp_dn[k][0] || ir_a[k] !== 1'b0 || wr_a[k] !== 1'b0 || rd_a[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL %s final inst=%0d: got wc=%0d ov=%b done=%b to=%b rdy=%b wr=%b rd=%b, expected wc=%0d ov=%0d done=%0d to=%0d rdy=0 wr=0 rd=0",
                         name, k, wc_a[k], ov_a[k], dn_a[k], tm_a[k], ir_a[k], wr_a[k], rd_a[k],
                         exp_wc[k], exp_ov[k], exp_dn[k], 1 - exp_dn[k]);
            end
        end
    endtask

    task automatic load_seq(input int n);
        bq.delete();
        for (int i = 1; i <= n; i++) bq.push_back(8'(i));
    endtask

    task automatic find_write(input int k, input int a, input logic [39:0] d, input string name);
        int hit = 0;
        foreach (obs[j]) if (obs[j].inst == k && obs[j].kind == 0 && obs[j].addr == a && obs[j].data === d) hit = 1;
        vectors++;
        if (hit == 0) begin
            miscompares++;
            $display("FAIL %s: got no write of %h at addr %0d on inst %0d, expected one", name, d, a, k);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; in_data = 8'h55; in_last = 1'b0; computation_end = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (ir_a[k] !== 1'b0 || wr_a[k] !== 1'b0 || rd_a[k] !== 1'b0 || addr_a[k] != 0 || wd_a[k] !== 40'h0
                || wc_a[k] != 0 || dn_a[k] !== 1'b0 || tm_a[k] !== 1'b0 || ov_a[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset inst=%0d: got rdy=%b wr=%b rd=%b addr=%0d wdata=%h wc=%0d done=%b to=%b ov=%b, expected all 0",
                         k, ir_a[k], wr_a[k], rd_a[k], addr_a[k], wd_a[k], wc_a[k], dn_a[k], tm_a[k], ov_a[k]);
            end
        end
        in_valid = 1'b0; computation_end = 1'b0;
    endtask

    task automatic test_spec_streams();
        do_reset();
        load_seq(10);
        run_stream(3, "ten_bytes_done");
        find_write(0, 0, 40'h0102030405, "be_word0");
        find_write(0, 1, 40'h060708090A, "be_word1");
        do_reset();
        load_seq(7);
        run_stream(-1, "seven_bytes_timeout");
        find_write(0, 1, 40'h0607000000, "be_flush");
        find_write(1, 0, 40'h0504030201, "le_word0");
        find_write(1, 1, 40'h0000000706, "le_flush");
    endtask

    task automatic test_frozen();
        repeat (6) @(negedge clk);
        vectors++;
        if (tm_a[0] !== 1'b1 || dn_a[0] !== 1'b0 || wr_a[0] !== 1'b0 || rd_a[0] !== 1'b0 || ir_a[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL frozen: got to=%b done=%b wr=%b rd=%b rdy=%b, expected to=1 done=0 wr=0 rd=0 rdy=0",
                     tm_a[0], dn_a[0], wr_a[0], rd_a[0], ir_a[0]);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        bq.delete();
        for (int i = 0; i < 25; i++) bq.push_back(8'($urandom));
        run_stream(10, "overflow");
    endtask

    task automatic test_reset_mid();
        int got = 0;
        int guard = 0;
        do_reset();
        in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b0;
        while (got < 2 && guard < 20) begin
            if (ir_a[0]) got++;
            @(negedge clk);
            guard++;
        end
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (ir_a[k] !== 1'b0 || wr_a[k] !== 1'b0 || wc_a[k] != 0 || addr_a[k] != 0 || wd_a[k] !== 40'h0) begin
                miscompares++;
                $display("FAIL mid_reset inst=%0d: got rdy=%b wr=%b wc=%0d addr=%0d wdata=%h, expected all 0",
                         k, ir_a[k], wr_a[k], wc_a[k], addr_a[k], wd_a[k]);
            end
        end
        in_valid = 1'b0;
        obs.delete();
        rst = 1'b1;
        bq.delete();
        for (int i = 0; i < 12; i++) bq.push_back(8'($urandom));
        run_stream(5, "after_mid_reset");
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int n   = $urandom_range(1, 32);
            int off = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, 60);
            do_reset();
            bq.delete();
            for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
            run_stream(off, "random");
        end
    endtask

    initial begin
        test_reset();
        test_spec_streams();
        test_frozen();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
